// File: rtl/spi_dac_rx.sv
// Dual-channel serial DAC-stream receiver: synchronizes the SPI-style inputs into clk,
// shifts both channels MSB first and publishes a sample pair when a frame closes with exactly WIDTH bits.
module spi_dac_rx #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_le,
  input  logic             spi_clk,
  input  logic             spi_dat_1,
  input  logic             spi_dat_2,
  input  logic             err_clr,
  output logic [WIDTH-1:0] sample_out_1,
  output logic [WIDTH-1:0] sample_out_2,
  output logic             sample_valid,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  // [0],[1] form the synchronizer; [2] is the previous synchronized value
  logic [2:0]       le_sync_q, le_sync_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat1_sync_q, dat1_sync_d;
  logic [1:0]       dat2_sync_q, dat2_sync_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift1_q, shift1_d;
  logic [WIDTH-1:0] shift2_q, shift2_d;
  logic [WIDTH-1:0] sample1_q, sample1_d;
  logic [WIDTH-1:0] sample2_q, sample2_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             clk_edge, frame_end;

  assign clk_edge  = clk_sync_q[1] & ~clk_sync_q[2];
  assign frame_end = ~le_sync_q[1] & le_sync_q[2];

  always_comb begin
    le_sync_d   = {le_sync_q[1:0], spi_le};
    clk_sync_d  = {clk_sync_q[1:0], spi_clk};
    dat1_sync_d = {dat1_sync_q[0], spi_dat_1};
    dat2_sync_d = {dat2_sync_q[0], spi_dat_2};
    cnt_d       = cnt_q;
    shift1_d    = shift1_q;
    shift2_d    = shift2_q;
    sample1_d   = sample1_q;
    sample2_d   = sample2_q;
    valid_d     = 1'b0;
    err_d       = err_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    // Frame end wins over a coincident bit clock; le_sync_q[1] is low then anyway
    if (frame_end) begin
      cnt_d = '0;
      if (cnt_q == CNT_FULL) begin
        sample1_d = shift1_q;
        sample2_d = shift2_q;
        valid_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (clk_edge && le_sync_q[1]) begin
      shift1_d = {shift1_q[WIDTH-2:0], dat1_sync_q[1]};
      shift2_d = {shift2_q[WIDTH-2:0], dat2_sync_q[1]};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      le_sync_q   <= '1;
      clk_sync_q  <= '0;
      dat1_sync_q <= '0;
      dat2_sync_q <= '0;
      cnt_q       <= '0;
      shift1_q    <= '0;
      shift2_q    <= '0;
      sample1_q   <= '0;
      sample2_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      le_sync_q   <= le_sync_d;
      clk_sync_q  <= clk_sync_d;
      dat1_sync_q <= dat1_sync_d;
      dat2_sync_q <= dat2_sync_d;
      cnt_q       <= cnt_d;
      shift1_q    <= shift1_d;
      shift2_q    <= shift2_d;
      sample1_q   <= sample1_d;
      sample2_q   <= sample2_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign sample_out_1 = sample1_q;
  assign sample_out_2 = sample2_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Directed bench for spi_dac_rx: frames of various lengths, long latch pulses,
// coincident edges, error clearing and mid-frame reset.
module tb_spi_dac_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_le, spi_clk, spi_dat_1, spi_dat_2, err_clr;
  logic [11:0] sample_out_1, sample_out_2;
  logic        sample_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt;
  int valid_pos;

  spi_dac_rx #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .spi_le(spi_le), .spi_clk(spi_clk),
    .spi_dat_1(spi_dat_1), .spi_dat_2(spi_dat_2), .err_clr(err_clr),
    .sample_out_1(sample_out_1), .sample_out_2(sample_out_2),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int n, input logic [31:0] d1, input logic [31:0] d2);
    for (int i = n - 1; i >= 0; i--) begin
      spi_dat_1 = d1[i];
      spi_dat_2 = d2[i];
      spi_clk   = 1'b0;
      tick();
      spi_clk   = 1'b1;
      tick();
    end
  endtask

  // Drops spi_le and records when sample_valid pulses (cycle index after spi_le low)
  task automatic close_frame(input bit coincident, input bit clr_at3);
    spi_clk = 1'b0;
    tick();
    spi_le = 1'b0;
    if (coincident) spi_clk = 1'b1;
    valid_cnt = 0;
    valid_pos = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (sample_valid) begin
        valid_cnt++;
        if (valid_pos == 0) valid_pos = c;
      end
      err_clr = (clr_at3 && c == 2);
    end
    err_clr = 1'b0;
    spi_clk = 1'b0;
    spi_le  = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_le = 1'b1; spi_clk = 1'b0; spi_dat_1 = 1'b0; spi_dat_2 = 1'b0; err_clr = 1'b0;
    tick(); tick();
    checks++; if (sample_out_1 !== 12'h000) begin errors++; $display("FAIL reset_s1 got %h exp 000", sample_out_1); end
    checks++; if (sample_out_2 !== 12'h000) begin errors++; $display("FAIL reset_s2 got %h exp 000", sample_out_2); end
    rst = 1'b0;
    valid_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sample_valid) valid_cnt++;
    end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL reset_release_valid got %0d exp 0", valid_cnt); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", frame_err); end
  endtask

  task automatic test_basic();
    send_bits(12, 32'hA5C, 32'h3F0);
    close_frame(1'b0, 1'b0);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL basic_valid_cnt got %0d exp 1", valid_cnt); end
    checks++; if (valid_pos !== 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", valid_pos); end
    checks++; if (sample_out_1 !== 12'hA5C) begin errors++; $display("FAIL basic_s1 got %h exp a5c", sample_out_1); end
    checks++; if (sample_out_2 !== 12'h3F0) begin errors++; $display("FAIL basic_s2 got %h exp 3f0", sample_out_2); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", frame_err); end
  endtask

  task automatic test_short_frame();
    send_bits(11, 32'h7FF, 32'h155);
    close_frame(1'b0, 1'b0);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL short_valid got %0d exp 0", valid_cnt); end
    checks++; if (sample_out_1 !== 12'hA5C) begin errors++; $display("FAIL short_s1 got %h exp a5c", sample_out_1); end
    checks++; if (sample_out_2 !== 12'h3F0) begin errors++; $display("FAIL short_s2 got %h exp 3f0", sample_out_2); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", frame_err); end
    clear_err();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_err_clr got %b exp 0", frame_err); end
  endtask

  task automatic test_long_frame();
    send_bits(14, 32'b11_0000_0000_0001, 32'h0);
    close_frame(1'b0, 1'b0);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL long_valid got %0d exp 0", valid_cnt); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL long_err got %b exp 1", frame_err); end
    checks++; if (sample_out_1 !== 12'hA5C) begin errors++; $display("FAIL long_s1 got %h exp a5c", sample_out_1); end
    send_bits(12, 32'h001, 32'hABC);
    close_frame(1'b0, 1'b0);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL after_long_valid got %0d exp 1", valid_cnt); end
    checks++; if (sample_out_1 !== 12'h001) begin errors++; $display("FAIL after_long_s1 got %h exp 001", sample_out_1); end
    checks++; if (sample_out_2 !== 12'hABC) begin errors++; $display("FAIL after_long_s2 got %h exp abc", sample_out_2); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", frame_err); end
    clear_err();
  endtask

  task automatic test_err_collision();
    send_bits(3, 32'h5, 32'h2);
    close_frame(1'b0, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL clr_set_collision got %b exp 1", frame_err); end
    checks++; if (sample_out_1 !== 12'h001) begin errors++; $display("FAIL collision_s1 got %h exp 001", sample_out_1); end
    clear_err();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL collision_clr got %b exp 0", frame_err); end
  endtask

  task automatic test_le_hold();
    send_bits(12, 32'h123, 32'h456);
    spi_clk = 1'b0;
    tick();
    spi_le = 1'b0;
    valid_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      spi_clk = (i == 4 || i == 8 || i == 12);
      tick();
      if (sample_valid) valid_cnt++;
    end
    spi_clk = 1'b0;
    spi_le  = 1'b1;
    tick(); tick(); tick();
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL le_hold_valid got %0d exp 1", valid_cnt); end
    checks++; if (sample_out_1 !== 12'h123) begin errors++; $display("FAIL le_hold_s1 got %h exp 123", sample_out_1); end
    send_bits(12, 32'hFFF, 32'h000);
    close_frame(1'b0, 1'b0);
    checks++; if (sample_out_1 !== 12'hFFF) begin errors++; $display("FAIL le_hold_next_s1 got %h exp fff", sample_out_1); end
    checks++; if (sample_out_2 !== 12'h000) begin errors++; $display("FAIL le_hold_next_s2 got %h exp 000", sample_out_2); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL le_hold_err got %b exp 0", frame_err); end
  endtask

  task automatic test_coincident();
    send_bits(12, 32'h5A5, 32'h0F0);
    close_frame(1'b1, 1'b0);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL coinc_valid got %0d exp 1", valid_cnt); end
    checks++; if (sample_out_1 !== 12'h5A5) begin errors++; $display("FAIL coinc_s1 got %h exp 5a5", sample_out_1); end
    send_bits(12, 32'h3C3, 32'hC3C);
    close_frame(1'b0, 1'b0);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL coinc_next_valid got %0d exp 1", valid_cnt); end
    checks++; if (sample_out_1 !== 12'h3C3) begin errors++; $display("FAIL coinc_next_s1 got %h exp 3c3", sample_out_1); end
    checks++; if (sample_out_2 !== 12'hC3C) begin errors++; $display("FAIL coinc_next_s2 got %h exp c3c", sample_out_2); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL coinc_err got %b exp 0", frame_err); end
  endtask

  task automatic test_mid_reset();
    send_bits(5, 32'h1F, 32'h00);
    close_frame(1'b0, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL pre_rst_err got %b exp 1", frame_err); end
    send_bits(6, 32'h2A, 32'h15);
    rst = 1'b1;
    spi_clk = 1'b0;
    #1;
    checks++; if (sample_out_1 !== 12'h000) begin errors++; $display("FAIL async_rst_s1 got %h exp 000", sample_out_1); end
    checks++; if (sample_out_2 !== 12'h000) begin errors++; $display("FAIL async_rst_s2 got %h exp 000", sample_out_2); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL async_rst_err got %b exp 0", frame_err); end
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    send_bits(12, 32'h800, 32'h7FF);
    close_frame(1'b0, 1'b0);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL post_rst_valid got %0d exp 1", valid_cnt); end
    checks++; if (sample_out_1 !== 12'h800) begin errors++; $display("FAIL post_rst_s1 got %h exp 800", sample_out_1); end
    checks++; if (sample_out_2 !== 12'h7FF) begin errors++; $display("FAIL post_rst_s2 got %h exp 7ff", sample_out_2); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL post_rst_err got %b exp 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frame();
    test_long_frame();
    test_err_collision();
    test_le_hold();
    test_coincident();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
